// File: rtl/el2_ifu_iccm_dma_arb_if.sv
// Port bundle for the ICCM DMA arbiter: DMA request/response, fetch handshake,
// fetch stall and PMU starvation indication.
interface el2_ifu_iccm_dma_arb_if #(
  parameter int TAG_W = 3
);
  logic             ifc_dma_access_ok;
  logic             dma_iccm_req;
  logic             dma_mem_write;
  logic [TAG_W-1:0] dma_mem_tag;
  logic             dma_iccm_gnt;
  logic             iccm_dma_rden;
  logic             iccm_dma_wren;
  logic             dma_iccm_stall_any;
  logic             iccm_dma_rvalid;
  logic [TAG_W-1:0] iccm_dma_rtag;
  logic             ifu_pmu_dma_starve;

  // Requesters: DMA controller and fetch control drive the request side.
  modport master (
    output ifc_dma_access_ok, dma_iccm_req, dma_mem_write, dma_mem_tag,
    input  dma_iccm_gnt, iccm_dma_rden, iccm_dma_wren, dma_iccm_stall_any,
           iccm_dma_rvalid, iccm_dma_rtag, ifu_pmu_dma_starve
  );

  // Arbiter side.
  modport slave (
    input  ifc_dma_access_ok, dma_iccm_req, dma_mem_write, dma_mem_tag,
    output dma_iccm_gnt, iccm_dma_rden, iccm_dma_wren, dma_iccm_stall_any,
           iccm_dma_rvalid, iccm_dma_rtag, ifu_pmu_dma_starve
  );
endinterface

// File: rtl/el2_ifu_iccm_dma_arb.sv
// ICCM port arbiter between fetch and DMA with starvation forcing and a fixed-latency
// read response pipe. Forcing logic is built only when RV_ICCM_DMA_STARVE_EN is defined.
module el2_ifu_iccm_dma_arb #(
  parameter int ICCM_LATENCY  = 2,
  parameter int DMA_MAX_WAIT  = 7,
  parameter int DMA_BURST_MAX = 4,
  parameter int TAG_W         = 3
) (
  input  logic                 clk,
  input  logic                 rst_l,
  el2_ifu_iccm_dma_arb_if.slave arb
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    FORCE = 2'b10
  } state_t;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hf) ? v : v + 4'd1;
  endfunction

  state_t           state, state_nxt;
  logic [3:0]       wait_cnt, wait_nxt;
  logic             req, gnt, rden, wren;
  logic             starve_q;

  assign req  = arb.dma_iccm_req;
  assign gnt  = req & arb.ifc_dma_access_ok;
  assign rden = gnt & ~arb.dma_mem_write;
  assign wren = gnt &  arb.dma_mem_write;

  assign arb.dma_iccm_gnt       = gnt;
  assign arb.iccm_dma_rden      = rden;
  assign arb.iccm_dma_wren      = wren;
  assign arb.ifu_pmu_dma_starve = starve_q;

`ifdef RV_ICCM_DMA_STARVE_EN
  localparam logic [3:0] MAX_WAIT_C  = 4'(DMA_MAX_WAIT);
  localparam logic [3:0] BURST_MAX_C = 4'(DMA_BURST_MAX);

  logic [3:0] burst_cnt, burst_nxt;
  logic       stall_q;

  assign arb.dma_iccm_stall_any = stall_q;
`else
  assign arb.dma_iccm_stall_any = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
`ifdef RV_ICCM_DMA_STARVE_EN
    burst_nxt = burst_cnt;
`endif
    case (state)
      IDLE: begin
        if (req & ~gnt) begin
          state_nxt = WAIT;
          wait_nxt  = 4'd1;
        end else begin
          wait_nxt  = 4'd0;
        end
      end
      WAIT: begin
        if (gnt | ~req) begin
          state_nxt = IDLE;
          wait_nxt  = 4'd0;
        end else begin
          wait_nxt  = sat_inc(wait_cnt);
`ifdef RV_ICCM_DMA_STARVE_EN
          // A grant in the same cycle wins over forcing (handled above).
          if (wait_cnt == MAX_WAIT_C) begin
            state_nxt = FORCE;
            burst_nxt = 4'd0;
          end
`endif
        end
      end
`ifdef RV_ICCM_DMA_STARVE_EN
      FORCE: begin
        if (gnt) begin
          burst_nxt = sat_inc(burst_cnt);
          wait_nxt  = 4'd0;
        end
        if (~req | (gnt & (sat_inc(burst_cnt) == BURST_MAX_C))) begin
          state_nxt = IDLE;
          wait_nxt  = 4'd0;
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
        wait_nxt  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      starve_q  <= 1'b0;
`ifdef RV_ICCM_DMA_STARVE_EN
      burst_cnt <= 4'd0;
      stall_q   <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      starve_q  <= (state_nxt != IDLE);
`ifdef RV_ICCM_DMA_STARVE_EN
      burst_cnt <= burst_nxt;
      stall_q   <= (state_nxt == FORCE);
`endif
    end
  end

  // Read response pipe: stage p0 captures the grant cycle, output taps stage ICCM_LATENCY-1.
  logic             vld_p0, vld_p1, vld_p2;
  logic [TAG_W-1:0] tag_p0, tag_p1, tag_p2;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      tag_p0 <= '0;
      tag_p1 <= '0;
      tag_p2 <= '0;
    end else begin
      vld_p0 <= rden;
      tag_p0 <= rden ? arb.dma_mem_tag : '0;
      vld_p1 <= vld_p0;
      tag_p1 <= tag_p0;
      vld_p2 <= vld_p1;
      tag_p2 <= tag_p1;
    end
  end

  assign arb.iccm_dma_rvalid = (ICCM_LATENCY == 1) ? vld_p0 :
                               (ICCM_LATENCY == 2) ? vld_p1 : vld_p2;
  assign arb.iccm_dma_rtag   = (ICCM_LATENCY == 1) ? tag_p0 :
                               (ICCM_LATENCY == 2) ? tag_p1 : tag_p2;

endmodule

// File: tb/tb_el2_ifu_iccm_dma_arb.sv
// Bench for el2_ifu_iccm_dma_arb: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a request-age model.
module tb_el2_ifu_iccm_dma_arb;
  localparam int L    = 2;
  localparam int MAXW = 7;
  localparam int BMAX = 4;
  localparam int TW   = 3;
`ifdef RV_ICCM_DMA_STARVE_EN
  localparam int STARVE = 1;
`else
  localparam int STARVE = 0;
`endif

  logic clk   = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  el2_ifu_iccm_dma_arb_if #(.TAG_W(TW)) arb_if ();

  el2_ifu_iccm_dma_arb #(
    .ICCM_LATENCY (L),
    .DMA_MAX_WAIT (MAXW),
    .DMA_BURST_MAX(BMAX),
    .TAG_W        (TW)
  ) dut (
    .clk  (clk),
    .rst_l(rst_l),
    .arb  (arb_if)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Behavioural model: a request's age (consecutive ungranted cycles) decides forcing;
  // forcing lasts until the request leaves or BMAX grants have been given.
  int            age       = 0;
  int            bursts    = 0;
  bit            forcing   = 0;
  int            exp_stall = 0;
  int            exp_starve = 0;
  logic [TW-1:0] resp[int];

  always @(negedge clk) begin
    bit r, o, g, w;
    r = arb_if.dma_iccm_req;
    o = arb_if.ifc_dma_access_ok;
    w = arb_if.dma_mem_write;
    g = r & o;
    chk("gnt",  int'(arb_if.dma_iccm_gnt),  int'(g));
    chk("rden", int'(arb_if.iccm_dma_rden), int'(g & ~w));
    chk("wren", int'(arb_if.iccm_dma_wren), int'(g & w));
    if (!rst_l) begin
      age = 0; bursts = 0; forcing = 0; exp_stall = 0; exp_starve = 0;
      resp.delete();
      chk("rtag_rst", int'(arb_if.iccm_dma_rtag), 0);
    end
    chk("stall",  int'(arb_if.dma_iccm_stall_any), exp_stall);
    chk("starve", int'(arb_if.ifu_pmu_dma_starve), exp_starve);
    chk("rvalid", int'(arb_if.iccm_dma_rvalid),    resp.exists(cyc));
    if (resp.exists(cyc)) begin
      chk("rtag", int'(arb_if.iccm_dma_rtag), int'(resp[cyc]));
      resp.delete(cyc);
    end
    if (rst_l) begin
      if (g && !w) resp[cyc + L] = arb_if.dma_mem_tag;
      if (forcing) begin
        if (!r) forcing = 0;
        else if (g) begin
          bursts++;
          if (bursts == BMAX) forcing = 0;
        end
      end else if (STARVE != 0 && r && !g && age == MAXW) begin
        forcing = 1;
        bursts  = 0;
      end
      age        = (r && !g) ? age + 1 : 0;
      exp_stall  = int'(forcing);
      exp_starve = int'(forcing | (r & ~g));
    end
    cyc++;
  end

  task automatic tick(input bit rs, input bit r, input bit o, input bit w,
                      input logic [TW-1:0] t);
    @(posedge clk); #1;
    rst_l                    = rs;
    arb_if.dma_iccm_req      = r;
    arb_if.ifc_dma_access_ok = o;
    arb_if.dma_mem_write     = w;
    arb_if.dma_mem_tag       = t;
    @(negedge clk); #1;
  endtask

  initial begin
    logic [7:0] ev;
    int         et[8];
    int         ngnt;
    bit r, o, w, rs;
    logic [TW-1:0] t;
    int okbias;

    arb_if.dma_iccm_req      = 1'b0;
    arb_if.ifc_dma_access_ok = 1'b0;
    arb_if.dma_mem_write     = 1'b0;
    arb_if.dma_mem_tag       = '0;

    // Reset state
    repeat (3) tick(0, 0, 0, 0, 0);
    chk("rst_stall",  int'(arb_if.dma_iccm_stall_any), 0);
    chk("rst_rvalid", int'(arb_if.iccm_dma_rvalid), 0);
    chk("rst_starve", int'(arb_if.ifu_pmu_dma_starve), 0);
    repeat (2) tick(1, 0, 0, 0, 0);

    // Opportunistic read, tag 5
    tick(1, 1, 1, 0, 5);
    chk("opp_gnt",  int'(arb_if.dma_iccm_gnt), 1);
    chk("opp_rden", int'(arb_if.iccm_dma_rden), 1);
    tick(1, 0, 0, 0, 0);
    chk("opp_rv1", int'(arb_if.iccm_dma_rvalid), 0);
    tick(1, 0, 0, 0, 0);
    chk("opp_rv2",   int'(arb_if.iccm_dma_rvalid), 1);
    chk("opp_rtag",  int'(arb_if.iccm_dma_rtag), 5);
    chk("opp_stall", int'(arb_if.dma_iccm_stall_any), 0);
    repeat (2) tick(1, 0, 0, 0, 0);

    // Starvation forcing
    for (int i = 0; i <= 8; i++) begin
      tick(1, 1, 0, 0, 2);
      if (i == 7) chk("stv_stall7", int'(arb_if.dma_iccm_stall_any), 0);
      if (i == 8) begin
        chk("stv_stall8",  int'(arb_if.dma_iccm_stall_any), STARVE);
        chk("stv_starve8", int'(arb_if.ifu_pmu_dma_starve), 1);
      end
    end
    tick(1, 1, 1, 0, 2);
    chk("stv_gnt9", int'(arb_if.dma_iccm_gnt), 1);
    tick(1, 0, 0, 0, 0);
    chk("stv_stall10",  int'(arb_if.dma_iccm_stall_any), STARVE);
    chk("stv_starve10", int'(arb_if.ifu_pmu_dma_starve), STARVE);
    tick(1, 0, 0, 0, 0);
    chk("stv_stall11", int'(arb_if.dma_iccm_stall_any), 0);
    repeat (2) tick(1, 0, 0, 0, 0);

    // Burst cap (writes only)
    for (int i = 0; i <= 8; i++) tick(1, 1, 0, 1, 0);
    ngnt = 0;
    for (int i = 9; i <= 12; i++) begin
      tick(1, 1, 1, 1, 0);
      ngnt += int'(arb_if.dma_iccm_gnt);
      if (i == 12) chk("burst_stall12", int'(arb_if.dma_iccm_stall_any), STARVE);
    end
    chk("burst_ngnt", ngnt, 4);
    tick(1, 0, 1, 1, 0);
    chk("burst_stall13", int'(arb_if.dma_iccm_stall_any), 0);
    repeat (2) tick(1, 0, 0, 0, 0);

    // Withdrawn request
    for (int i = 0; i < 3; i++) begin
      tick(1, 1, 0, 0, 3);
      chk("wdr_gnt", int'(arb_if.dma_iccm_gnt), 0);
    end
    chk("wdr_starve2", int'(arb_if.ifu_pmu_dma_starve), 1);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    chk("wdr_starve4", int'(arb_if.ifu_pmu_dma_starve), 0);
    chk("wdr_stall4",  int'(arb_if.dma_iccm_stall_any), 0);

    // Mixed reads/writes: R1 R2 W R3
    ev = 8'b0010_1100;
    et = '{0, 0, 1, 2, 0, 3, 0, 0};
    for (int k = 0; k < 8; k++) begin
      case (k)
        0: tick(1, 1, 1, 0, 1);
        1: tick(1, 1, 1, 0, 2);
        2: tick(1, 1, 1, 1, 7);
        3: tick(1, 1, 1, 0, 3);
        default: tick(1, 0, 0, 0, 0);
      endcase
      chk("mix_rv", int'(arb_if.iccm_dma_rvalid), int'(ev[k]));
      if (ev[k]) chk("mix_tag", int'(arb_if.iccm_dma_rtag), et[k]);
    end

    // Reset one cycle after a read grant
    tick(1, 1, 1, 0, 6);
    tick(0, 0, 0, 0, 0);
    chk("mrst_rv1", int'(arb_if.iccm_dma_rvalid), 0);
    tick(0, 0, 0, 0, 0);
    chk("mrst_rv2", int'(arb_if.iccm_dma_rvalid), 0);
    tick(1, 0, 0, 0, 0);
    chk("mrst_rv3",     int'(arb_if.iccm_dma_rvalid), 0);
    chk("mrst_stall",   int'(arb_if.dma_iccm_stall_any), 0);
    chk("mrst_starve",  int'(arb_if.ifu_pmu_dma_starve), 0);

    // Randomized traffic
    r = 0; o = 0; w = 0; t = '0; rs = 1; okbias = 5;
    for (int n = 0; n < 3000; n++) begin
      if (n % 500 == 0) okbias = $urandom_range(1, 8);
      if (r && !o && rs) begin
        if ($urandom_range(0, 19) == 0) r = 0;
      end else begin
        r = ($urandom_range(0, 3) != 0);
        w = ($urandom_range(0, 2) == 0);
        t = TW'($urandom_range(0, 7));
      end
      o  = ($urandom_range(0, 9) < okbias);
      rs = ($urandom_range(0, 399) != 0);
      tick(rs, r, o, w, t);
    end
    repeat (4) tick(1, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
